// File: rtl/nth_prime_pkg.sv
// Shared types for the nth-prime decoder: FSM states, trial-division step
// results and the default datapath width.
package nth_prime_pkg;

    localparam int WIDTH_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CONTINUE,
        PRIME,
        COMPOSITE
    } step_t;

endpackage

// File: rtl/trial_div_step.sv
// One trial-division evaluation: decides whether candidate c is settled as
// prime or composite by divisor d, or whether the next divisor is needed.
module trial_div_step
    import nth_prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output step_t            result
);

    logic [2*WIDTH-1:0] d_sq;
    logic [2*WIDTH-1:0] c_ext;
    logic [WIDTH-1:0]   rem;

    // Full-width square so large divisors cannot alias to a small product.
    assign d_sq  = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign c_ext = {{WIDTH{1'b0}}, c};
    assign rem   = c % d;

    always_comb begin
        result = CONTINUE;
        if (d_sq > c_ext) begin
            result = PRIME;
        end else if (rem == '0) begin
            result = COMPOSITE;
        end
    end

endmodule

// File: rtl/nth_prime_finder.sv
// Returns the index-th prime by trial division, one divisor per cycle.
// Define NTH_PRIME_STATS_EN to add the test_count cycle counter output.
//
// state | meaning
// IDLE  | waiting for start; last result held on prime_value/err
// TEST  | one trial-division step per cycle on candidate c, divisor d
// DONE  | single-cycle done pulse, then back to IDLE
module nth_prime_finder
    import nth_prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] index,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prime_value,
    output logic             err
`ifdef NTH_PRIME_STATS_EN
    ,
    output logic [15:0]      test_count
`endif
);

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t           state;
    step_t            step;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] n;

    trial_div_step #(.WIDTH(WIDTH)) u_step (
        .c      (c),
        .d      (d),
        .result (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            prime_value <= '0;
            err         <= 1'b0;
            c           <= TWO;
            d           <= TWO;
            f           <= '0;
            n           <= '0;
`ifdef NTH_PRIME_STATS_EN
            test_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef NTH_PRIME_STATS_EN
                        test_count <= '0;
`endif
                        if (index == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            err         <= 1'b1;
                            prime_value <= '0;
                        end else begin
                            n     <= index;
                            c     <= TWO;
                            d     <= TWO;
                            f     <= '0;
                            busy  <= 1'b1;
                            state <= TEST;
                        end
                    end
                end
                TEST: begin
`ifdef NTH_PRIME_STATS_EN
                    if (test_count != 16'hFFFF) begin
                        test_count <= test_count + 16'd1;
                    end
`endif
                    case (step)
                        PRIME: begin
                            if (f + ONE == n) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                prime_value <= c;
                                err         <= 1'b0;
                            end else if (c == C_MAX) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                prime_value <= '0;
                                err         <= 1'b1;
                            end else begin
                                f <= f + ONE;
                                c <= c + ONE;
                                d <= TWO;
                            end
                        end
                        COMPOSITE: begin
                            // Max-candidate check comes first so c never wraps.
                            if (c == C_MAX) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                prime_value <= '0;
                                err         <= 1'b1;
                            end else begin
                                c <= c + ONE;
                                d <= TWO;
                            end
                        end
                        default: begin
                            d <= d + ONE;
                        end
                    endcase
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nth_prime_finder.sv
// Self-checking bench for nth_prime_finder: vector table plus corner sequences,
// with a scoreboard of expected results consumed on each done pulse.
module tb_nth_prime_finder;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] index;
    logic         busy;
    logic         done;
    logic [W-1:0] prime_value;
    logic         err;
`ifdef NTH_PRIME_STATS_EN
    logic [15:0]  test_count;
`endif

    nth_prime_finder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .index       (index),
        .busy        (busy),
        .done        (done),
        .prime_value (prime_value),
        .err         (err)
`ifdef NTH_PRIME_STATS_EN
        ,
        .test_count  (test_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int prime;
        int err;
        int lat;
    } vec_t;

    typedef struct {
        int prime;
        int err;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    int n_vec       = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int busy_cycles = 0;
    int done_pulses = 0;

    localparam int BUDGET = 40000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: done seen with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("prime_value", int'(prime_value), e.prime);
                    check("err", int'(err), e.err);
                    if (e.lat >= 0) check("latency", cyc - e.start_cyc, e.lat);
                end
            end
        end
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < BUDGET && done_pulses == d0; k++) @(posedge clk);
        if (done_pulses == d0) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles", BUDGET);
            sb.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input int idx, input int exp_prime, input int exp_err, input int exp_lat);
        int b0;
        int d0;
        @(negedge clk);
        #1;
        start = 1'b1;
        index = W'(idx);
        b0 = busy_cycles;
        d0 = done_pulses;
        sb.push_back('{exp_prime, exp_err, exp_lat, cyc});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0);
        check("done_pulse_count", done_pulses - d0, 1);
        check("done_low_after", int'(done), 0);
        if (exp_lat >= 0) check("busy_cycles", busy_cycles - b0, exp_lat - 1);
`ifdef NTH_PRIME_STATS_EN
        check("test_count", int'(test_count), busy_cycles - b0);
`endif
    endtask

    initial begin
        int d0;
        vecs[0] = '{1, 2, 0, 2};
        vecs[1] = '{3, 5, 0, 6};
        vecs[2] = '{0, 0, 1, 1};
        vecs[3] = '{2, 3, 0, 3};
        vecs[4] = '{4, 7, 0, 9};
        vecs[5] = '{10, 29, 0, -1};
        vecs[6] = '{25, 97, 0, -1};
        vecs[7] = '{309, 2039, 0, -1};
        vecs[8] = '{310, 0, 1, -1};

        rst   = 1'b1;
        start = 1'b0;
        index = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_prime_value", int'(prime_value), 0);
        check("rst_err", int'(err), 0);
`ifdef NTH_PRIME_STATS_EN
        check("rst_test_count", int'(test_count), 0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) do_req(vecs[i].idx, vecs[i].prime, vecs[i].err, vecs[i].lat);

        // start hammered while busy: must be ignored, one result only
        @(negedge clk);
        #1;
        start = 1'b1;
        index = W'(25);
        d0 = done_pulses;
        sb.push_back('{97, 0, -1, cyc});
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            start = ~start;
            index = W'(7);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(d0);
        check("hammer_done_count", done_pulses - d0, 1);
        do_req(2, 3, 0, 3);

        // reset in the middle of a search
        @(negedge clk);
        #1;
        start = 1'b1;
        index = W'(100);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        d0 = done_pulses;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_prime_value", int'(prime_value), 0);
        check("abort_err", int'(err), 0);
`ifdef NTH_PRIME_STATS_EN
        check("abort_test_count", int'(test_count), 0);
`endif
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_pulses - d0, 0);
        check("abort_idle_busy", int'(busy), 0);
        do_req(100, 541, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
